// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor built from GROUP-bit lookahead groups.
// Latency: result visible two clock edges after the beat is presented; 1 beat/cycle throughput.
// Backpressure: valid/ready; in_ready = !v1 | !v2 | out_ready, stalled stages hold data and valid.
`timescale 1ns/1ps
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || WIDTH < 4) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be >= 4 and a multiple of GROUP");
    end

    // Flat sum-of-products carry out of bits lo..hi given the carry into bit lo.
    function automatic logic la_carry(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                      input logic ci, input int lo, input int hi);
        logic c;
        logic t;
        c = ci;
        for (int j = lo; j <= hi; j++) c = c & p[j];
        for (int j = lo; j <= hi; j++) begin
            t = g[j];
            for (int m = j + 1; m <= hi; m++) t = t & p[m];
            c = c | t;
        end
        return c;
    endfunction

    // Same lookahead form applied across groups 0..hi.
    function automatic logic la_group(input logic [NG-1:0] g, input logic [NG-1:0] p,
                                      input logic ci, input int hi);
        logic c;
        logic t;
        c = ci;
        for (int j = 0; j <= hi; j++) c = c & p[j];
        for (int j = 0; j <= hi; j++) begin
            t = g[j];
            for (int m = j + 1; m <= hi; m++) t = t & p[m];
            c = c | t;
        end
        return c;
    endfunction

    // Handshake: each stage advances when it is empty or the stage after it advances.
    logic v1, v2, adv1, adv2;
    assign adv2     = !v2 | out_ready;
    assign adv1     = !v1 | adv2;
    assign in_ready = adv1;

    // Operand conditioning: subtract is a + ~b + ~cin.
    logic [WIDTH-1:0] beff, p_in, g_in;
    logic             ceff;
    logic [NG-1:0]    gg_in, gp_in;
    assign beff = b ^ {WIDTH{sub}};
    assign ceff = cin ^ sub;
    assign p_in = a ^ beff;
    assign g_in = a & beff;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        assign gg_in[k] = la_carry(g_in, p_in, 1'b0, k * GROUP, k * GROUP + GROUP - 1);
        assign gp_in[k] = &p_in[k*GROUP +: GROUP];
    end

    // Stage 1 state. The MSB generate is not kept: it is rebuilt from the sign pair.
    logic [WIDTH-1:0] p1;
    logic [WIDTH-2:0] g1;
    logic [NG-1:0]    gg1, gp1;
    logic             c1, as1, bs1;

    // Stage 1: capture per-bit and per-group propagate/generate when the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            p1  <= '0;
            g1  <= '0;
            gg1 <= '0;
            gp1 <= '0;
            c1  <= 1'b0;
            as1 <= 1'b0;
            bs1 <= 1'b0;
        end else if (adv1) begin
            v1  <= in_valid;
            p1  <= p_in;
            g1  <= g_in[WIDTH-2:0];
            gg1 <= gg_in;
            gp1 <= gp_in;
            c1  <= ceff;
            as1 <= a[WIDTH-1];
            bs1 <= beff[WIDTH-1];
        end
    end

    // Second-level lookahead: group carries, then bit carries inside each group.
    logic [NG:0]      gc;
    logic [WIDTH-1:0] bc;
    logic [WIDTH-1:0] g1_full;
    logic             msb_cout;
    assign g1_full = {1'b0, g1};
    assign gc[0]   = c1;

    for (genvar k = 0; k < NG; k++) begin : g_gc
        assign gc[k+1] = la_group(gg1, gp1, c1, k);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bc
        localparam int K    = i / GROUP;
        localparam int BASE = K * GROUP;
        if (i == BASE) begin : g_first
            assign bc[i] = gc[K];
        end else begin : g_rest
            assign bc[i] = la_carry(g1_full, p1, gc[K], BASE, i - 1);
        end
    end

    assign msb_cout = (as1 & bs1) | ((as1 ^ bs1) & bc[WIDTH-1]);

    // Stage 2: register the result; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (adv2) begin
            v2   <= v1;
            sum  <= p1 ^ bc;
            cout <= gc[NG];
            ovf  <= bc[WIDTH-1] ^ msb_cout;
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: 16/4 directed vectors plus a 32/8 random sweep against an integer model.
// Latency: checks the two-edge result latency and order through a scoreboard queue.
// Backpressure: stalls out_ready, checks in_ready drop, held outputs, and recovery to 1 beat/cycle.
`timescale 1ns/1ps
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
    logic [15:0] a16, b16, s16;
    logic        iv32, ir32, ov32, or32, cin32, sub32, co32, of32;
    logic [31:0] a32, b32, s32;

    int checks = 0;
    int errors = 0;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(co16), .ovf(of16));

    cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
        .cout(co32), .ovf(of32));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic longint pk(input longint s, input bit co, input bit ov);
        return (s << 2) | (longint'(co) << 1) | longint'(ov);
    endfunction

    // Result from plain integer arithmetic: unsigned range for cout, signed range for ovf.
    function automatic longint model(input int w, input longint ua, input longint ub,
                                     input bit c, input bit s);
        longint m, half, sa, sb, ur, sr, cl;
        bit co, ov;
        m    = longint'(1) << w;
        half = m >> 1;
        cl   = longint'(c);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (s) begin
            ur = ua - ub - cl;
            sr = sa - sb - cl;
            co = (ur >= 0);
        end else begin
            ur = ua + ub + cl;
            sr = sa + sb + cl;
            co = (ur >= m);
        end
        ov = (sr < -half) || (sr >= half);
        return pk(ur & (m - 1), co, ov);
    endfunction

    typedef struct {
        logic [15:0] a, b;
        bit          cin, sub;
        logic [15:0] s;
        bit          co, ov;
    } vec_t;

    vec_t tbl[6] = '{
        '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1}
    };

    // Scoreboards: push on accept, pop on consume, check holds during stalls.
    longint q16[$];
    longint q32[$];
    bit     hold16, hold32;
    longint held16, held32;
    int     acc32 = 0;
    int     pop32 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete();
            hold16 = 1'b0;
        end else begin
            if (hold16) begin
                chk("hold16_valid", longint'(ov16), 1);
                chk("hold16_data", pk(s16, co16, of16), held16);
            end
            if (iv16 && ir16) q16.push_back(model(16, a16, b16, cin16, sub16));
            hold16 = 1'b0;
            if (ov16) begin
                if (!or16) begin
                    hold16 = 1'b1;
                    held16 = pk(s16, co16, of16);
                end else if (q16.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out16_unexpected: got beat %0h, expected no beat", pk(s16, co16, of16));
                end else begin
                    chk("out16", pk(s16, co16, of16), q16.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            hold32 = 1'b0;
        end else begin
            if (hold32) begin
                chk("hold32_valid", longint'(ov32), 1);
                chk("hold32_data", pk(s32, co32, of32), held32);
            end
            if (iv32 && ir32) begin
                q32.push_back(model(32, a32, b32, cin32, sub32));
                acc32++;
            end
            hold32 = 1'b0;
            if (ov32) begin
                if (!or32) begin
                    hold32 = 1'b1;
                    held32 = pk(s32, co32, of32);
                end else if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out32_unexpected: got beat %0h, expected no beat", pk(s32, co32, of32));
                end else begin
                    chk("out32", pk(s32, co32, of32), q32.pop_front());
                    pop32++;
                end
            end
        end
    end

    // Offer one beat (called just after a rising edge); returns just after the accepting edge.
    task automatic send16(input logic [15:0] aa, input logic [15:0] bb, input bit cc, input bit ss);
        bit ok;
        a16 = aa; b16 = bb; cin16 = cc; sub16 = ss; iv16 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ir16;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send16_timeout: got in_ready 0 for 50 cycles, expected 1");
        end
    endtask

    initial begin
        bit seen;
        int n;
        rst_n = 1'b0;
        iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 1;
        iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 1;
        #1;
        chk("rst_out_valid", longint'(ov16), 0);
        chk("rst_sum", longint'(s16), 0);
        chk("rst_cout", longint'(co16), 0);
        chk("rst_ovf", longint'(of16), 0);
        chk("rst_out_valid32", longint'(ov32), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("in_ready_after_reset", longint'(ir16), 1);

        // Pin the model with hand-computed results.
        foreach (tbl[i])
            chk("model_pin16", model(16, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub),
                pk(tbl[i].s, tbl[i].co, tbl[i].ov));
        chk("model_pin32_add", model(32, 64'h80000000, 64'h80000000, 0, 0), pk(0, 1, 1));
        chk("model_pin32_sub", model(32, 64'h12345678, 64'h12345678, 1, 1), pk(64'hFFFFFFFF, 0, 0));

        // Latency: presented after E0, invisible after E1, visible after E2.
        @(posedge clk); #1;
        a16 = 16'h1234; b16 = 16'h4321; cin16 = 0; sub16 = 0; iv16 = 1;
        @(posedge clk); #1;
        iv16 = 0;
        chk("lat_edge1_valid", longint'(ov16), 0);
        @(posedge clk); #1;
        chk("lat_edge2_valid", longint'(ov16), 1);
        chk("lat_edge2_sum", longint'(s16), 64'h5555);
        chk("lat_edge2_flags", {co16, of16}, 0);

        // Directed vectors back to back.
        foreach (tbl[i]) send16(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
        iv16 = 0;
        repeat (6) @(posedge clk);
        #1 chk("directed_drained", q16.size(), 0);

        // Backpressure: five beats, consumer stalls four cycles after the first result.
        fork
            begin
                for (int i = 0; i < 5; i++) send16(16'h1000 * (i + 1), 16'h0101 * (i + 3), i[0], i[1]);
                iv16 = 0;
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(posedge clk); #1;
                    seen = ov16;
                end
                chk("bp_first_result", longint'(seen), 1);
                or16 = 0;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", longint'(ir16), 0);
                    chk("bp_out_valid_held", longint'(ov16), 1);
                    @(posedge clk); #1;
                end
                or16 = 1;
                n = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (ov16) n++;
                end
                chk("bp_throughput", n, 5);
            end
        join
        repeat (4) @(posedge clk);
        #1 chk("bp_drained", q16.size(), 0);

        // Reset with two beats in flight.
        send16(16'h0011, 16'h0022, 0, 0);
        send16(16'h0033, 16'h0044, 0, 0);
        iv16 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(ov16), 0);
        chk("midrst_sum", longint'(s16), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_stale", longint'(ov16), 0);
        end
        @(posedge clk); #1;
        send16(16'h0001, 16'h0002, 0, 0);
        iv16 = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = ov16;
        end
        chk("midrst_next_seen", longint'(seen), 1);
        chk("midrst_next_sum", longint'(s16), 3);

        // WIDTH=32 GROUP=8 random sweep with random valid and ready.
        for (int cyc = 0; cyc < 20000 && acc32 < 1000; cyc++) begin
            a32   = $urandom;
            b32   = $urandom;
            cin32 = 1'($urandom_range(0, 1));
            sub32 = 1'($urandom_range(0, 1));
            iv32  = ($urandom_range(0, 3) != 0);
            or32  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        iv32 = 0;
        or32 = 1;
        chk("sweep_accepted", acc32, 1000);
        for (int i = 0; i < 50 && q32.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sweep_drained", q32.size(), 0);
        chk("sweep_results", pop32, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
